// File: rtl/hex_key_pkg.sv
// Shared types and constants for the hex key encoder front end.
package hex_key_pkg;

  localparam int NUM_KEYS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic KIND_ADD = 1'b0;
  localparam logic KIND_DEL = 1'b1;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Lowest set index wins when several digits are pending at once.
  function automatic logic [3:0] lowest_index(input logic [NUM_KEYS-1:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = i[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex_key_debounce.sv
// Single-bit synchronizer plus tick-sampled debouncer with a one-cycle change flag.
module hex_key_debounce #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic change
);

  logic [1:0]                sync_r;
  logic [STABLE_SAMPLES-2:0] hist_r;
  logic [STABLE_SAMPLES-1:0] hist_nxt_s;
  logic                      level_r;
  logic                      change_r;

  // Newest sample joins the stored history to form the full window.
  assign hist_nxt_s = {hist_r, sync_r[1]};

  // Synchronize, shift history on tick, and accept a level once the window agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= 2'b00;
      hist_r   <= '0;
      level_r  <= 1'b0;
      change_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      if (tick) begin
        hist_r <= hist_nxt_s[STABLE_SAMPLES-2:0];
        if ((&hist_nxt_s) && !level_r) begin
          level_r  <= 1'b1;
          change_r <= 1'b1;
        end else if (!(|hist_nxt_s) && level_r) begin
          level_r  <= 1'b0;
          change_r <= 1'b1;
        end else begin
          change_r <= 1'b0;
        end
      end else begin
        change_r <= 1'b0;
      end
    end
  end

  assign level  = level_r;
  assign change = change_r;

endmodule

// File: rtl/hex_key_encoder.sv
// Debounced hex keypad front end emitting spaced add/del strobes.
// Define HEX_KEY_ANY_EDGE_EN to make both switch edges enter a digit.
module hex_key_encoder
  import hex_key_pkg::*;
#(
  parameter int TICK_CYCLES    = 100000,
  parameter int STABLE_SAMPLES = 4,
  parameter int GAP_CYCLES     = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] sw,
  input  logic                btn_del,
  output logic [3:0]          hex,
  output logic                add,
  output logic                del,
  output logic                busy
);

  localparam int TW = clog2(TICK_CYCLES);
  localparam int AW = clog2(STABLE_SAMPLES + 1);
  localparam int GW = clog2(GAP_CYCLES);

  logic [TW-1:0]       tick_cnt_r;
  logic                tick_s;
  logic [AW-1:0]       arm_cnt_r;
  logic                armed_r;
  logic [NUM_KEYS-1:0] key_level_s, key_change_s;
  logic                del_level_s, del_change_s;
  logic [NUM_KEYS-1:0] pending_r, key_set_s, key_clr_s, pend_nxt_s;
  logic                del_pending_r, del_set_s, del_clr_s, del_nxt_s;
  state_t              state_r;
  logic [GW-1:0]       gap_cnt_r;
  logic                gap_done_s, go_s, kind_s, busy_nxt_s;
  logic [3:0]          pick_s;
  logic [3:0]          hex_r;
  logic                add_r, del_r, busy_r;

  assign tick_s = (tick_cnt_r == TW'(TICK_CYCLES - 1));

  // Free-running debounce sample tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Arms one cycle after the first full window so its change flags are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_cnt_r <= '0;
      armed_r   <= 1'b0;
    end else if (arm_cnt_r == AW'(STABLE_SAMPLES)) begin
      armed_r <= 1'b1;
    end else if (tick_s) begin
      arm_cnt_r <= arm_cnt_r + AW'(1);
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    hex_key_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw[i]),
      .tick   (tick_s),
      .level  (key_level_s[i]),
      .change (key_change_s[i])
    );
  end

  hex_key_debounce #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db_del (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_del),
    .tick   (tick_s),
    .level  (del_level_s),
    .change (del_change_s)
  );

  // Event capture, selection and next pending state; a same-cycle set beats a clear.
  always_comb begin
    key_set_s = '0;
    del_set_s = 1'b0;
    key_clr_s = '0;
    del_clr_s = 1'b0;
    if (armed_r) begin
`ifdef HEX_KEY_ANY_EDGE_EN
      key_set_s = key_change_s;
`else
      key_set_s = key_change_s & key_level_s;
`endif
      del_set_s = del_change_s & del_level_s;
    end else begin
      key_set_s = '0;
      del_set_s = 1'b0;
    end
    go_s   = (state_r == ST_IDLE) && (del_pending_r || (pending_r != '0));
    kind_s = del_pending_r ? KIND_DEL : KIND_ADD;
    pick_s = lowest_index(pending_r);
    if (go_s) begin
      if (kind_s == KIND_DEL) begin
        del_clr_s = 1'b1;
      end else begin
        key_clr_s = {{(NUM_KEYS-1){1'b0}}, 1'b1} << pick_s;
      end
    end else begin
      del_clr_s = 1'b0;
    end
    pend_nxt_s = (pending_r & ~key_clr_s) | key_set_s;
    del_nxt_s  = (del_pending_r & ~del_clr_s) | del_set_s;
    gap_done_s = (state_r == ST_GAP) && (gap_cnt_r == GW'(GAP_CYCLES - 3));
    busy_nxt_s = go_s || (state_r == ST_EMIT) || ((state_r == ST_GAP) && !gap_done_s)
                 || (pend_nxt_s != '0) || del_nxt_s;
  end

  // Strobe FSM: GAP plus the IDLE decision cycle spaces strobes exactly GAP_CYCLES apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      gap_cnt_r     <= '0;
      pending_r     <= '0;
      del_pending_r <= 1'b0;
      hex_r         <= 4'h0;
      add_r         <= 1'b0;
      del_r         <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      pending_r     <= pend_nxt_s;
      del_pending_r <= del_nxt_s;
      busy_r        <= busy_nxt_s;
      add_r         <= 1'b0;
      del_r         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          gap_cnt_r <= '0;
          if (go_s) begin
            state_r <= ST_EMIT;
            if (kind_s == KIND_DEL) begin
              del_r <= 1'b1;
            end else begin
              add_r <= 1'b1;
              hex_r <= pick_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          state_r   <= ST_GAP;
          gap_cnt_r <= '0;
        end
        ST_GAP: begin
          if (gap_done_s) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= '0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gap_cnt_r <= '0;
        end
      endcase
    end
  end

  assign hex  = hex_r;
  assign add  = add_r;
  assign del  = del_r;
  assign busy = busy_r;

endmodule

// File: doc/hex_key_encoder.md
Name: hex_key_encoder

Overview:
- Front-end input stage that feeds the 32-bit hex-entry register. It directly drives that register's hex/add/del inputs.
- Samples 16 board switches (one per hex digit 0..F) and a delete button, then debounces and edge-detects them.
- Emits single-cycle add or del strobes with the matching 4-bit hex code.
- Queues simultaneous events and enforces a minimum spacing between strobes, so the downstream register never drops an entry during its refractory period.

Parameters:
- TICK_CYCLES, 100000, clk cycles per debounce sample tick (1 ms at 100 MHz).
- STABLE_SAMPLES, 4, consecutive equal tick samples required to accept a new input level (min 2).
- GAP_CYCLES, 10000000, minimum clk cycles from one strobe to the next (100 ms; must be ≥ downstream refractory).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous active-high reset.
- sw  in  16  raw asynchronous switches; sw[i] is hex digit i.
- btn_del  in  1  raw asynchronous delete button.
- hex  out  4  digit code; valid while add=1 and held until the next add.
- add  out  1  one-cycle strobe: append hex.
- del  out  1  one-cycle strobe: delete last digit.
- busy  out  1  high in EMIT/GAP or whenever any event is pending.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - hex=0, add=0, del=0, busy=0.
  - pending mask, del_pending, tick counter, gap counter, sample histories and stable levels all cleared.
  - armed=0; FSM returns to IDLE.
  - Reset mid-EMIT or mid-GAP abandons the event; nothing is emitted after reset deasserts.
- Synchronizer: two flops on each of the 17 raw inputs. No other logic touches the raw inputs.
- Tick: counter runs 0..TICK_CYCLES-1 and wraps. tick=1 on the wrap cycle.
- Debounce, per input, on each tick:
  - Shift the synchronized bit into a STABLE_SAMPLES-deep history.
  - If the history is all-equal and differs from the stable level, update the stable level and raise a one-cycle change flag.
- Arming: armed sets after the first STABLE_SAMPLES ticks following reset.
  - Each stable level loads the all-equal history value at that point.
  - Change flags raised before armed=1 are discarded, so switches already on at reset generate no events.
- Events (armed only):
  - Rising stable edge on sw[i] sets pending[i].
  - Rising stable edge on btn_del sets del_pending.
  - Falling edges are ignored (see optional feature).
  - An edge on an already-pending bit merges with it: one emission only.
- FSM states: IDLE, EMIT, GAP.
  - IDLE: if del_pending, go to EMIT with kind=DEL and clear del_pending. Else if pending≠0, pick the lowest set index k, go to EMIT with kind=ADD, code=k, and clear pending[k]. Else stay.
  - Delete has priority over add.
  - If a new edge sets the same bit in the cycle it is cleared, the set wins.
  - EMIT (exactly 1 cycle): add=1 with hex=k, or del=1. hex is unchanged for del. Then go to GAP with the gap counter at 0.
  - GAP: count to GAP_CYCLES-2, then go to IDLE. The next strobe comes ≥ GAP_CYCLES cycles after the previous strobe.
  - Events arriving during GAP stay pending.
- Latency: the change flag registers pending at cycle N. With the FSM idle, the strobe is at cycle N+2.
- add and del are never high together. Both are registered outputs.

Optional Feature:
- Macro HEX_KEY_ANY_EDGE_EN.
- Defined: both rising and falling stable edges of sw[i] set pending[i], so each switch toggle enters a digit. btn_del still uses rising edge only.
- Undefined: only rising edges of sw[i] count.

Decomposition:
- Package hex_key_pkg holds:
  - NUM_KEYS=16.
  - FSM state encodings ST_IDLE, ST_EMIT, ST_GAP.
  - Event kind constants KIND_ADD, KIND_DEL.
  - A clog2 helper function for counter widths.
- Sub-module hex_key_debounce (single bit: synchronizer, history shift, stable level, change flag). It takes tick as an input and is instantiated 17 times.
- Tick counter, arming logic, pending logic and FSM live in the top.

Test Plan (TICK_CYCLES=4, STABLE_SAMPLES=3, GAP_CYCLES=8):
- Reset with sw=16'h0010 held, then release rst and wait 40 cycles -> no add/del pulse; busy=0.
- After arming, set sw[5]=1 and hold -> exactly one add pulse, 1 cycle wide, hex=4'h5; no second pulse while held.
- Toggle sw[2] 1->0->1 every cycle for 6 cycles, then hold at 1 -> exactly one add with hex=2 after stabilization.
- In one cycle raise sw[9], sw[3] and btn_del -> del first, then add hex=3, then add hex=9; consecutive strobes exactly 8 cycles apart.
- Raise sw[7] during GAP -> add hex=7 is emitted on the first EMIT after GAP ends, not earlier.
- Assert rst during GAP with pending[1] set -> no strobe after release; busy=0. With HEX_KEY_ANY_EDGE_EN, a falling sw[5] produces add hex=5.
